// File: rtl/psum_writeback.sv
// Packs pairs of 32-bit partial sums from a PE row into 64-bit psum memory words.
// An odd trailing psum is written alone into the low half with byte enables 8'h0F.
module psum_writeback #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [CNT_W-1:0]  i_num_psums,
  input  logic              i_in_valid,
  input  logic [31:0]       i_in_data,
  output logic              o_in_ready,
  output logic [7:0]        o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [63:0]       o_mem_din,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_base;
  logic [CNT_W-1:0]    r_num;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_widx;
  logic [31:0]         r_low;
  logic [7:0]          r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [63:0]         r_mem_din;
  logic                w_xfer;
  logic                w_last;
  logic                w_take_job;

  assign o_in_ready = (r_state == S_RUN) && (r_cnt < r_num);
  assign w_xfer     = i_in_valid && o_in_ready;
  // r_num is nonzero whenever RUN is active, so the decrement cannot underflow there.
  assign w_last     = (r_cnt == (r_num - {{(CNT_W-1){1'b0}}, 1'b1}));
  assign w_take_job = (r_state == S_IDLE) && i_start && (i_num_psums != {CNT_W{1'b0}});

  assign o_mem_we   = r_mem_we;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_din  = r_mem_din;
  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = (r_state == S_DONE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next = (i_num_psums == {CNT_W{1'b0}}) ? S_DONE : S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_xfer && w_last) begin
          w_next = r_num[0] ? S_FLUSH : S_DONE;
        end else begin
          w_next = S_RUN;
        end
      end
      S_FLUSH: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The lone-psum write is registered on the final transfer so it is visible during FLUSH.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_base     <= {ADDR_W{1'b0}};
      r_num      <= {CNT_W{1'b0}};
      r_cnt      <= {CNT_W{1'b0}};
      r_widx     <= {ADDR_W{1'b0}};
      r_low      <= 32'h0000_0000;
      r_mem_we   <= 8'h00;
      r_mem_addr <= {ADDR_W{1'b0}};
      r_mem_din  <= 64'h0;
    end else begin
      r_mem_we <= 8'h00;
      if (w_take_job) begin
        r_base <= i_base_addr;
        r_num  <= i_num_psums;
        r_cnt  <= {CNT_W{1'b0}};
        r_widx <= {ADDR_W{1'b0}};
      end else if (w_xfer) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        if (r_cnt[0] == 1'b0) begin
          r_low <= i_in_data;
          if (w_last) begin
            r_mem_we   <= 8'h0F;
            r_mem_addr <= r_base + r_widx;
            r_mem_din  <= {32'h0000_0000, i_in_data};
            r_widx     <= r_widx + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end else begin
          r_mem_we   <= 8'hFF;
          r_mem_addr <= r_base + r_widx;
          r_mem_din  <= {i_in_data, r_low};
          r_widx     <= r_widx + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_writeback.sv
// Randomized bench for psum_writeback: expected writes are derived from the psum list
// (pairs packed high/low, odd tail in the low half) and compared with observed writes.
module tb_psum_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'h0;
  logic [15:0] num_psums = 16'h0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        in_ready;
  logic [7:0]  mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_din;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0]  q_we[$];
  logic [31:0] q_addr[$];
  logic [63:0] q_din[$];
  int          q_cyc[$];
  int          done_cnt;
  int          done_cyc;

  psum_writeback #(.ADDR_W(32), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base_addr),
    .i_num_psums(num_psums), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_in_ready(in_ready), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_din(mem_din), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we != 8'h00) begin
      q_we.push_back(mem_we);
      q_addr.push_back(mem_addr);
      q_din.push_back(mem_din);
      q_cyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    q_we.delete(); q_addr.delete(); q_din.delete(); q_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic check_idle_outputs(input string name);
    n_tests++;
    if ({mem_we, mem_addr, mem_din, busy, done, in_ready} !== 110'h0) begin
      n_fail++;
      $display("FAIL %s: got we=%h addr=%h din=%h busy=%b done=%b rdy=%b, required all zero",
               name, mem_we, mem_addr, mem_din, busy, done, in_ready);
    end
  endtask

  // Caller is 1 time unit after a rising edge; start is sampled at the next edge.
  task automatic run_job(input logic [31:0] base, input int n, input int gap_pct,
                         input bit spurious, input string name);
    logic [31:0] d[$];
    logic [31:0] exp_addr;
    logic [63:0] exp_din;
    logic [7:0]  exp_we;
    int i, guard, exp_writes, s_cyc, last;
    for (int k = 0; k < n; k++) d.push_back($urandom);
    clear_mon();
    start = 1'b1; base_addr = base; num_psums = n[15:0];
    @(posedge clk); #1;
    s_cyc = cyc;
    start = 1'b0; base_addr = $urandom; num_psums = $urandom;
    i = 0; guard = 0;
    while (i < n && guard < 2000) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = in_valid ? d[i] : $urandom;
      if (spurious && i == 2) begin
        start = 1'b1; base_addr = base + 32'd100; num_psums = 16'd2;
      end else begin
        start = 1'b0;
      end
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL %s ready: got %b at psum %0d, required 1", name, in_ready, i);
      end
      @(posedge clk);
      if (in_valid) i++;
      #1;
      guard++;
    end
    start = 1'b0; in_valid = 1'b0; in_data = $urandom;
    n_tests++;
    if (i != n) begin
      n_fail++;
      $display("FAIL %s budget: accepted %0d psums, required %0d", name, i, n);
    end
    repeat (4) @(posedge clk);
    #1;
    exp_writes = (n + 1) / 2;
    n_tests++;
    if (q_we.size() != exp_writes) begin
      n_fail++;
      $display("FAIL %s write count: got %0d, required %0d", name, q_we.size(), exp_writes);
    end
    for (int k = 0; k < exp_writes && k < q_we.size(); k++) begin
      exp_addr = base + k;
      if (2 * k + 1 < n) begin
        exp_we = 8'hFF; exp_din = {d[2*k+1], d[2*k]};
      end else begin
        exp_we = 8'h0F; exp_din = {32'h0, d[2*k]};
      end
      n_tests++;
      if (q_we[k] !== exp_we || q_addr[k] !== exp_addr || q_din[k] !== exp_din) begin
        n_fail++;
        $display("FAIL %s write %0d: got we=%h addr=%h din=%h, required we=%h addr=%h din=%h",
                 name, k, q_we[k], q_addr[k], q_din[k], exp_we, exp_addr, exp_din);
      end
    end
    n_tests++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL %s done count: got %0d, required 1", name, done_cnt);
    end
    if (q_cyc.size() > 0 && q_cyc.size() == exp_writes) begin
      last = q_cyc[q_cyc.size()-1] + ((n % 2 == 1) ? 1 : 0);
      n_tests++;
      if (done_cyc != last || done_cyc <= s_cyc) begin
        n_fail++;
        $display("FAIL %s done timing: got cycle %0d, required %0d", name, done_cyc, last);
      end
    end
    n_tests++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s end state: got busy=%b rdy=%b, required 0/0", name, busy, in_ready);
    end
  endtask

  task automatic test_reset();
    #3;
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("post_reset");
  endtask

  task automatic test_even();
    run_job(32'h10, 4, 0, 1'b0, "even4");
  endtask

  task automatic test_odd();
    run_job(32'h20, 3, 0, 1'b0, "odd3");
  endtask

  task automatic test_zero();
    clear_mon();
    start = 1'b1; base_addr = 32'h30; num_psums = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zero first: got busy=%b done=%b rdy=%b, required 1/1/0", busy, done, in_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero after: got busy=%b done=%b, required 0/0", busy, done);
    end
    repeat (2) @(posedge clk); #1;
    n_tests++;
    if (q_we.size() != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL zero writes: got %0d writes %0d dones, required 0 writes 1 done",
               q_we.size(), done_cnt);
    end
  endtask

  task automatic test_gaps_spurious();
    run_job(32'h0000_0500, 6, 45, 1'b1, "gaps6");
  endtask

  task automatic test_wrap();
    run_job(32'hFFFF_FFFF, 4, 0, 1'b0, "wrap4");
  endtask

  task automatic test_reset_midjob();
    start = 1'b1; base_addr = 32'h40; num_psums = 16'd8;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("midjob_reset");
    clear_mon();
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    run_job(32'h80, 2, 0, 1'b0, "after_reset2");
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 8; j++) begin
      run_job($urandom, $urandom_range(1, 9), (j % 2 == 0) ? 0 : 30, 1'b0, "b2b");
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_even();
    test_odd();
    test_zero();
    test_gaps_spurious();
    test_wrap();
    test_reset_midjob();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_writeback.md
PSUM_WRITEBACK -- requirements
Module: psum_writeback

Interface
REQ-001 Parameter ADDR_W, default 32, width of the psum memory word address.
REQ-002 Parameter CNT_W, default 16, width of the psum count.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins a writeback job; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_W  first 64-bit word address of the job; captured on accepted start.
REQ-007 num_psums  input  CNT_W  number of 32-bit psums in the job; captured on accepted start.
REQ-008 in_valid  input  1  psum from the PE row is valid.
REQ-009 in_data  input  32  psum value.
REQ-010 in_ready  output  1  block accepts in_data this cycle.
REQ-011 mem_we  output  8  byte write enables to the psum memory row port.
REQ-012 mem_addr  output  ADDR_W  64-bit word address (word index, not byte address).
REQ-013 mem_din  output  64  packed write data.
REQ-014 busy  output  1  job in progress.
REQ-015 done  output  1  one-cycle pulse at job completion.

Function
REQ-016 States: IDLE, RUN, FLUSH, DONE; one state register.
REQ-017 IDLE: start=1 with num_psums>0 -> RUN, capture base_addr/num_psums, clear accept counter and word index.
REQ-018 IDLE: start=1 with num_psums=0 -> DONE directly; no memory write.
REQ-019 start while not IDLE is ignored; captured job parameters stay unchanged.
REQ-020 in_ready = 1 only in RUN while accepted count < captured num_psums; combinational from state and counter.
REQ-021 Transfer occurs when in_valid && in_ready; in_data ignored otherwise.
REQ-022 Even-indexed transfer (0,2,4,...): in_data is held in a low-half register; no write issued.
REQ-023 Odd-indexed transfer: the next cycle drives mem_we=8'hFF, mem_din={in_data, held low half}, mem_addr=base_addr+word index; word index increments after the write.
REQ-024 mem_we, mem_addr, mem_din are registered; mem_we=8'h00 in every cycle without a write; mem_addr/mem_din hold their last value when not writing.
REQ-025 Final transfer with even total: RUN -> DONE; the last full write appears in the first DONE cycle.
REQ-026 Final transfer with odd total: RUN -> FLUSH; the FLUSH cycle drives mem_we=8'h0F, mem_din={32'h0, held low half}, mem_addr=base_addr+word index; then FLUSH -> DONE.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE. With even totals, done coincides with the last write cycle; with odd totals, done follows the 8'h0F write by one cycle.
REQ-028 busy=1 in RUN, FLUSH, DONE; 0 in IDLE.
REQ-029 Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
REQ-030 Back-to-back transfers at one per cycle are sustained with no bubbles; in_valid gaps pause packing without loss.
REQ-031 Total writes per job = ceil(num_psums/2); no write is issued outside a job.

Reset
REQ-032 rst=1 forces state IDLE, counters 0, low-half register 0, mem_we=8'h00, mem_addr=0, mem_din=0, done=0, busy=0, regardless of clk.
REQ-033 Reset mid-job abandons the job; no further writes or done pulse; a new start is accepted in the first cycle after rst deasserts.

Verification
REQ-034 base_addr=0x10, num_psums=4, data 1,2,3,4 on consecutive cycles -> writes {2,1}@0x10 and {4,3}@0x11, we=FF each; done in the same cycle as the second write.
REQ-035 base_addr=0x20, num_psums=3, data A,B,C -> {B,A}@0x20 we=FF, then {0,C}@0x21 we=0F, done one cycle later.
REQ-036 num_psums=0 -> done pulse one cycle after start, busy high for that one cycle, mem_we never nonzero.
REQ-037 num_psums=6 with in_valid toggling randomly, plus a second start during the job -> exactly 3 writes at base..base+2, correct pairing, second start ignored.
REQ-038 base_addr=0xFFFFFFFF, num_psums=4 -> writes at 0xFFFFFFFF then 0x00000000.
REQ-039 rst asserted after 3 of 8 psums accepted -> outputs cleared asynchronously, no done; a subsequent job of 2 psums completes normally.
